// File: rtl/pixel_frame_store.sv
// Pixel frame store: WIDTH x HEIGHT 3-bit pixel memory with a single write port
// shared by plot requests and a full-frame fill, and a paced raster read port.
module pixel_frame_store #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       clear_req,
  input  logic [2:0] clear_colour,
  output logic       busy,
  output logic       wr_dropped,
  input  logic       scan_en,
  output logic [7:0] out_x,
  output logic [6:0] out_y,
  output logic [2:0] out_colour,
  output logic       out_valid,
  output logic       frame_start
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q;
  logic          busy_q;
  logic [14:0]   clr_addr_q;
  logic [2:0]    clr_col_q;

  logic [2:0]    mem [DEPTH];

  logic          plot_ok;
  logic          wr_en;
  logic [14:0]   wr_addr;
  logic [2:0]    wr_data;
  logic [14:0]   plot_addr;
  logic [14:0]   scan_addr;
  logic          issue;

  logic [DW-1:0] div_q, div_d;
  logic [7:0]    sx_q, sx_d;
  logic [6:0]    sy_q, sy_d;
  logic [7:0]    out_x_q, out_x_d;
  logic [6:0]    out_y_q, out_y_d;
  logic [2:0]    out_colour_q, out_colour_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          wr_dropped_q, wr_dropped_d;

  // Fill sequencer: one address per cycle while CLEAR, busy registered alongside state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      clr_addr_q <= '0;
      clr_col_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q    <= CLEAR;
            busy_q     <= 1'b1;
            clr_addr_q <= '0;
            clr_col_q  <= clear_colour;
          end
        end
        CLEAR: begin
          // clear_req is deliberately not looked at here: a request during a fill is dropped
          if (clr_addr_q == 15'(DEPTH - 1)) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            clr_addr_q <= '0;
          end else begin
            clr_addr_q <= clr_addr_q + 15'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write-port arbitration: the fill owns the port while busy, otherwise an in-range plot
  always_comb begin
    plot_addr = 15'(y) * 15'(WIDTH) + 15'(x);
    plot_ok   = plot && !busy_q && (int'(x) < WIDTH) && (int'(y) < HEIGHT);
    wr_en     = busy_q || plot_ok;
    wr_addr   = busy_q ? clr_addr_q : plot_addr;
    wr_data   = busy_q ? clr_col_q  : colour;
  end

  // Pixel memory write; no reset, contents are defined only once written
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Scan pacing, raster position and read-result staging
  always_comb begin
    scan_addr     = 15'(sy_q) * 15'(WIDTH) + 15'(sx_q);
    issue         = scan_en && (div_q == DW'(CLK_DIV - 1));
    div_d         = div_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    out_x_d       = out_x_q;
    out_y_d       = out_y_q;
    out_colour_d  = out_colour_q;
    out_valid_d   = issue;
    frame_start_d = issue && (sx_q == 8'd0) && (sy_q == 7'd0);
    wr_dropped_d  = plot && !plot_ok;
    if (scan_en) div_d = issue ? '0 : div_q + DW'(1);
    if (issue) begin
      // mem still holds pre-write data here, so a same-cycle write is not seen
      out_x_d      = sx_q;
      out_y_d      = sy_q;
      out_colour_d = mem[scan_addr];
      if (sx_q == 8'(WIDTH - 1)) begin
        sx_d = '0;
        sy_d = (sy_q == 7'(HEIGHT - 1)) ? '0 : sy_q + 7'd1;
      end else begin
        sx_d = sx_q + 8'd1;
      end
    end
  end

  // Scan and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      out_colour_q  <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      wr_dropped_q  <= 1'b0;
    end else begin
      div_q         <= div_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      out_colour_q  <= out_colour_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      wr_dropped_q  <= wr_dropped_d;
    end
  end

  assign busy        = busy_q;
  assign wr_dropped  = wr_dropped_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_colour  = out_colour_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pixel_frame_store.sv
// Bench for pixel_frame_store: behavioural model of memory, fill timing and
// raster order, compared against the DUT on every falling edge.
module tb_pixel_frame_store;
  localparam int W  = 160;
  localparam int H  = 120;
  localparam int CD = 2;
  localparam int N  = W * H;

  logic       clk = 0, rst = 0, plot = 0, clear_req = 0, scan_en = 0;
  logic [7:0] x = 0;
  logic [6:0] y = 0;
  logic [2:0] colour = 0, clear_colour = 0;
  logic       busy, wr_dropped, out_valid, frame_start;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;

  pixel_frame_store #(.WIDTH(W), .HEIGHT(H), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .plot(plot), .x(x), .y(y), .colour(colour),
    .clear_req(clear_req), .clear_colour(clear_colour), .busy(busy),
    .wr_dropped(wr_dropped), .scan_en(scan_en), .out_x(out_x), .out_y(out_y),
    .out_colour(out_colour), .out_valid(out_valid), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0] mem_m [N];
  bit         known [N];
  int  cyc = 0, clr_start = 0, en_cnt = 0, iss_cnt = 0;
  bit  clr_on = 0;
  logic [2:0] clr_col = 0;
  bit  exp_busy = 0, exp_drop = 0, exp_valid = 0, exp_fs = 0, exp_known = 0;
  int  exp_x = 0, exp_y = 0, exp_col = 0;

  always @(posedge clk or negedge rst) begin
    bit busy_now, in_rng;
    int idx;
    if (!rst) begin
      cyc = 0; clr_on = 0; en_cnt = 0; iss_cnt = 0;
      exp_busy = 0; exp_drop = 0; exp_valid = 0; exp_fs = 0;
    end else begin
      busy_now = clr_on && cyc > clr_start && cyc <= clr_start + N;
      exp_valid = 0; exp_fs = 0;
      if (scan_en) begin
        if (en_cnt % CD == CD - 1) begin
          idx = iss_cnt % N;
          exp_valid = 1;
          exp_x = idx % W;
          exp_y = idx / W;
          exp_col = int'(mem_m[idx]);
          exp_known = known[idx];
          exp_fs = (idx == 0);
          iss_cnt++;
        end
        en_cnt++;
      end
      in_rng = (int'(x) < W) && (int'(y) < H);
      exp_drop = plot && (busy_now || !in_rng);
      if (busy_now) begin
        mem_m[cyc - clr_start - 1] = clr_col;
        known[cyc - clr_start - 1] = 1;
      end else if (plot && in_rng) begin
        mem_m[int'(y) * W + int'(x)] = colour;
        known[int'(y) * W + int'(x)] = 1;
      end
      if (!busy_now && clear_req) begin
        clr_on = 1; clr_start = cyc; clr_col = clear_colour;
      end
      cyc++;
      exp_busy = clr_on && cyc > clr_start && cyc <= clr_start + N;
    end
  end

  // ---------------- compare process ----------------
  int valid_cnt = 0, nz_cnt = 0, c57 = -1, wrap_seen = 0;
  int prev_x = -1, prev_y = -1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_drop", int'(wr_dropped), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_fs", int'(frame_start), 0);
      chk("rst_oxyc", int'({out_x, out_y, out_colour}), 0);
      prev_x = -1; prev_y = -1;
    end else begin
      chk("busy", int'(busy), int'(exp_busy));
      chk("wr_dropped", int'(wr_dropped), int'(exp_drop));
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("frame_start", int'(frame_start), int'(exp_fs));
      if (exp_valid) begin
        chk("out_x", int'(out_x), exp_x);
        chk("out_y", int'(out_y), exp_y);
        if (exp_known) chk("out_colour", int'(out_colour), exp_col);
        valid_cnt++;
        if (out_colour != 0) nz_cnt++;
        if (out_x == 5 && out_y == 7) c57 = int'(out_colour);
        if (prev_x == W - 1 && prev_y == H - 1) begin
          chk("wrap_x", int'(out_x), 0);
          chk("wrap_y", int'(out_y), 0);
          chk("wrap_fs", int'(frame_start), 1);
          wrap_seen++;
        end
        prev_x = int'(out_x); prev_y = int'(out_y);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic rand_plot(input int pct);
    plot   = ($urandom_range(0, 99) < pct);
    x      = 8'($urandom_range(0, 175));
    y      = 7'($urandom_range(0, 127));
    colour = 3'($urandom);
  endtask

  initial begin
    int n, pv, guard;
    bit paused;
    logic [7:0] pat;

    repeat (4) tick();
    rst = 1;
    tick();

    // full fill with 0, busy length
    clear_colour = 3'b000; clear_req = 1;
    tick();
    clear_req = 0;
    n = 0;
    while (busy && n < 20000) begin n++; tick(); end
    chk("busy_len_first", n, 19200);

    // plot and out-of-range rejects
    plot = 1; x = 5; y = 7; colour = 3'b100;
    tick();
    plot = 0;
    chk("plot_ok_nodrop", int'(wr_dropped), 0);
    plot = 1; x = 160; y = 0; colour = 3'b111;
    tick();
    plot = 0;
    chk("drop_x", int'(wr_dropped), 1);
    tick();
    chk("drop_x_end", int'(wr_dropped), 0);
    plot = 1; x = 0; y = 120; colour = 3'b111;
    tick();
    plot = 0;
    chk("drop_y", int'(wr_dropped), 1);
    tick();
    chk("drop_y_end", int'(wr_dropped), 0);

    // first full frame: pacing, single lit pixel, pause mid-frame
    valid_cnt = 0; nz_cnt = 0; c57 = -1; wrap_seen = 0;
    scan_en = 1;
    pat = 0;
    repeat (8) begin tick(); pat = {pat[6:0], out_valid}; end
    chk("valid_pattern", int'(pat), 8'b0101_0101);
    guard = 0; paused = 0;
    while (valid_cnt < N && guard < 45000) begin
      guard++;
      if (valid_cnt == 10000 && !paused) begin
        paused = 1;
        scan_en = 0; pv = 0;
        repeat (10) begin tick(); pv += int'(out_valid); end
        chk("pause_no_valid", pv, 0);
        scan_en = 1;
      end
      tick();
    end
    chk("frame1_count", valid_cnt, N);
    chk("frame1_nonzero", nz_cnt, 1);
    chk("pixel_5_7", c57, 3'b100);
    repeat (10) tick();
    chk("wrap_seen", wrap_seen, 1);

    // random plots with random scan gating
    repeat (3000) begin
      rand_plot(30);
      scan_en = ($urandom_range(0, 3) != 0);
      tick();
    end
    plot = 0;

    // plot + clear together, plots during busy, ignored second request
    plot = 1; x = 3; y = 0; colour = 3'b111;
    clear_colour = 3'($urandom); clear_req = 1;
    tick();
    plot = 0; clear_req = 0;
    n = 0;
    while (busy && n < 20000) begin
      n++;
      rand_plot(10);
      scan_en = ($urandom_range(0, 3) != 0);
      if (n == 50) begin clear_req = 1; clear_colour = 3'($urandom); end
      if (n == 100) begin plot = 1; x = 10; y = 10; colour = 3'b101; end
      tick();
      clear_req = 0;
      if (n == 100) chk("drop_busy", int'(wr_dropped), 1);
    end
    plot = 0;
    chk("busy_len_second", n, 19200);
    scan_en = 1;
    repeat (600) tick();

    // reset during a fill
    clear_colour = 3'b101; clear_req = 1;
    tick();
    clear_req = 0;
    repeat (100) tick();
    chk("busy_before_rst", int'(busy), 1);
    rst = 0;
    #1;
    chk("busy_async_rst", int'(busy), 0);
    repeat (3) tick();
    rst = 1;
    tick();
    clear_colour = 3'b110; clear_req = 1;
    tick();
    clear_req = 0;
    chk("clear_after_rst", int'(busy), 1);
    repeat (300) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
